// File: rtl/mult64_seq_if.sv
// ============================================================================
// Module      : mult64_seq_if
// Description : Operand/product handshake bundle for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult64_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             is_signed;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;

  modport master (
    output in_valid, A, B, is_signed, flush, out_ready,
    input  in_ready, out_valid, prod_lo, prod_hi
  );

  modport slave (
    input  in_valid, A, B, is_signed, flush, out_ready,
    output in_ready, out_valid, prod_lo, prod_hi
  );
endinterface

`default_nettype wire

// File: rtl/mult64_seq.sv
// ============================================================================
// Module      : mult64_seq
// Description : Radix-2 shift-add multiplier (MUL/UMULH/SMULH), one shared adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add64 (
  input  wire logic [63:0] i_a,
  input  wire logic [63:0] i_b,
  output logic      [63:0] o_sum,
  output logic             o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

module mult64_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  wire logic    clk,
  input  wire logic    reset_n,
  mult64_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic                 r_neg;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_prod_hi;
  logic [WIDTH-1:0]     r_prod_lo;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [2*WIDTH-1:0]   w_acc_neg;

  assign w_accept    = (r_state == S_IDLE) && bus.in_valid && !bus.flush;
  // |-2^63| wraps to 2^63, which is exactly right when read as unsigned.
  assign w_abs_a     = (bus.is_signed && bus.A[WIDTH-1]) ? (~bus.A + 1'b1) : bus.A;
  assign w_abs_b     = (bus.is_signed && bus.B[WIDTH-1]) ? (~bus.B + 1'b1) : bus.B;
  assign w_addend    = r_acc_lo[0] ? r_mcand : '0;
  assign w_acc_neg   = ~{r_acc_hi, r_acc_lo} + 1'b1;

  add64 u_add (
    .i_a    (r_acc_hi),
    .i_b    (w_addend),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = S_SIGN;
      S_SIGN:  w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_abs_a;
      r_acc_hi <= '0;
      r_acc_lo <= w_abs_b;
      r_neg    <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      r_cnt    <= '0;
    end else if (!bus.flush) begin
      if (r_state == S_BUSY) begin
        {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
        r_cnt                <= r_cnt + 1'b1;
      end else if (r_state == S_SIGN) begin
        // Product registers are separate so they keep the last result while the next one iterates.
        if (r_neg) begin
          {r_acc_hi, r_acc_lo}   <= w_acc_neg;
          {r_prod_hi, r_prod_lo} <= w_acc_neg;
        end else begin
          {r_prod_hi, r_prod_lo} <= {r_acc_hi, r_acc_lo};
        end
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.prod_hi   = r_prod_hi;
  assign bus.prod_lo   = r_prod_lo;

endmodule

`default_nettype wire
